// File: rtl/mdio_target.sv
// MDIO target: recovers generator frames on MDC rising edges and bridges
// them to a 32 x 16-bit register-file port.
// Ports: clk, rst (async, active-low); MDC, MDIO_OUT, MDIO_OE from the
// generator; RD_DATA from the register file; MDIO_IN, MDIO_IN_VLD back
// to the generator; REG_ADDR, WR_DATA, WR_STB, RD_REQ to the register
// file; FRAME_ERR abort pulse; BUSY while a frame is in flight.
module mdio_target #(
  parameter logic [4:0] PHY_ADDR = 5'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic [15:0] MDIO_IN,
  output logic        MDIO_IN_VLD,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_REQ,
  output logic        FRAME_ERR,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    READ_DATA,
    WRITE_DATA,
    SKIP
  } state_t;

  state_t      state;
  logic        mdc_q;
  logic [5:0]  bcnt;
  logic [31:0] sr;
  logic        rd_pend;

  logic        ev;
  logic [31:0] nxt;
  logic        last_bit;
  logic        st_ok;
  logic        hit14;
  logic        rd14;
  logic        hit16;
  logic        rd16;
  logic        unused_bits;

  assign ev       = MDC & ~mdc_q;
  assign nxt      = {sr[30:0], MDIO_OUT};
  assign last_bit = (bcnt == 6'd31);
  assign BUSY     = (state != IDLE);

  // Field views of the shift register including the bit being sampled.
  // After 2 bits ST is in [1:0]; after 14 bits OP/PHYADDR/REGADDR are in
  // [11:10]/[9:5]/[4:0]; after 16 bits OP/PHYADDR have moved up by two.
  assign st_ok = (nxt[1:0] == 2'b01);
  assign hit14 = (nxt[9:5] == PHY_ADDR);
  assign rd14  = (nxt[11:10] == 2'b00);
  assign hit16 = (nxt[11:7] == PHY_ADDR);
  assign rd16  = (nxt[13:12] == 2'b00);

  assign unused_bits = ^{sr[31], nxt[31:16]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mdc_q       <= 1'b0;
      bcnt        <= '0;
      sr          <= '0;
      rd_pend     <= 1'b0;
      MDIO_IN     <= '0;
      MDIO_IN_VLD <= 1'b0;
      REG_ADDR    <= '0;
      WR_DATA     <= '0;
      WR_STB      <= 1'b0;
      RD_REQ      <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      mdc_q     <= MDC;
      WR_STB    <= 1'b0;
      RD_REQ    <= 1'b0;
      FRAME_ERR <= 1'b0;

      // The register file answers the cycle after RD_REQ.
      rd_pend <= RD_REQ;
      if (rd_pend) begin
        MDIO_IN     <= RD_DATA;
        MDIO_IN_VLD <= 1'b1;
      end

      if (ev) begin
        case (state)
          IDLE: begin
            if (MDIO_OE) begin
              sr          <= nxt;
              bcnt        <= 6'd1;
              state       <= HEADER;
              MDIO_IN_VLD <= 1'b0;
            end
          end

          HEADER: begin
            if (!MDIO_OE) begin
              FRAME_ERR <= 1'b1;
              bcnt      <= '0;
              state     <= IDLE;
            end else begin
              sr   <= nxt;
              bcnt <= bcnt + 6'd1;
              if (bcnt == 6'd1 && !st_ok) begin
                FRAME_ERR <= 1'b1;
                state     <= SKIP;
              end
              if (bcnt == 6'd13 && hit14) begin
                REG_ADDR <= nxt[4:0];
                RD_REQ   <= rd14;
              end
              if (bcnt == 6'd15) begin
                if (!hit16) begin
                  state <= SKIP;
                end else if (rd16) begin
                  state <= READ_DATA;
                end else begin
                  state <= WRITE_DATA;
                end
              end
            end
          end

          // Generator has released the line; just count bits out.
          READ_DATA: begin
            sr <= nxt;
            if (last_bit) begin
              bcnt  <= '0;
              state <= IDLE;
            end else begin
              bcnt <= bcnt + 6'd1;
            end
          end

          WRITE_DATA: begin
            if (!MDIO_OE) begin
              FRAME_ERR <= 1'b1;
              bcnt      <= '0;
              state     <= IDLE;
            end else begin
              sr <= nxt;
              if (last_bit) begin
                WR_DATA <= nxt[15:0];
                WR_STB  <= 1'b1;
                bcnt    <= '0;
                state   <= IDLE;
              end else begin
                bcnt <= bcnt + 6'd1;
              end
            end
          end

          SKIP: begin
            if (!MDIO_OE || last_bit) begin
              bcnt  <= '0;
              state <= IDLE;
            end else begin
              sr   <= nxt;
              bcnt <= bcnt + 6'd1;
            end
          end

          default: begin
            bcnt  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_target.sv
// Bench for mdio_target: directed frame table, random frames against a
// frame-level model, and a mid-frame reset sequence.
module tb_mdio_target;

  localparam logic [4:0] PHY = 5'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA = 16'hDEAD;
  logic [15:0] MDIO_IN;
  logic        MDIO_IN_VLD;
  logic [4:0]  REG_ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_REQ;
  logic        FRAME_ERR;
  logic        BUSY;

  mdio_target #(.PHY_ADDR(PHY)) dut (
    .clk        (clk),
    .rst        (rst),
    .MDC        (MDC),
    .MDIO_OUT   (MDIO_OUT),
    .MDIO_OE    (MDIO_OE),
    .RD_DATA    (RD_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDIO_IN_VLD(MDIO_IN_VLD),
    .REG_ADDR   (REG_ADDR),
    .WR_DATA    (WR_DATA),
    .WR_STB     (WR_STB),
    .RD_REQ     (RD_REQ),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #5 clk = ~clk;

  // Register file: data only valid the cycle after RD_REQ.
  logic [15:0] mem [32];
  always @(posedge clk)
    RD_DATA <= RD_REQ ? mem[REG_ADDR] : 16'hDEAD;

  // Event monitor.
  int         wr_n = 0, rd_n = 0, err_n = 0, both_n = 0;
  logic [4:0] wr_reg = '0, rd_reg = '0;
  logic [15:0] wr_data = '0;
  always @(negedge clk) begin
    if (WR_STB) begin
      wr_n    <= wr_n + 1;
      wr_reg  <= REG_ADDR;
      wr_data <= WR_DATA;
    end
    if (RD_REQ) begin
      rd_n   <= rd_n + 1;
      rd_reg <= REG_ADDR;
    end
    if (FRAME_ERR) err_n <= err_n + 1;
    if (WR_STB && RD_REQ) both_n <= both_n + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] frame;
    int          drop;
    int          hi;
    int          lo;
    logic        exp_wr;
    logic        exp_rd;
    logic        exp_err;
    logic        exp_err2;
    logic        exp_busy32;
  } vec_t;

  // Frame-level outcome from the protocol rules. drop = first bit
  // (1-based) driven with OE low, OE staying low after; 0 = never.
  function automatic vec_t model(logic [31:0] f, int d, int hi, int lo);
    vec_t v;
    logic ok_st, hit, rd_op, started, hdr_ok;
    ok_st   = (f[31:30] == 2'b01);
    hit     = (f[27:23] == PHY);
    rd_op   = (f[29:28] == 2'b00);
    started = (d != 1);
    hdr_ok  = (d == 0) || (d > 16);
    v.frame      = f;
    v.drop       = d;
    v.hi         = hi;
    v.lo         = lo;
    v.exp_rd     = ok_st && hit && rd_op && (d == 0 || d >= 15);
    v.exp_wr     = ok_st && hit && !rd_op && (d == 0);
    v.exp_err    = started &&
                   (!ok_st || !hdr_ok || (hit && !rd_op && d != 0));
    v.exp_err2   = started && (d == 2 || !ok_st);
    v.exp_busy32 = (d == 0) || (ok_st && hit && rd_op && d >= 17);
    return v;
  endfunction

  logic        o_rd14, o_wr32, o_err2, o_vld16, o_busy32;
  logic [15:0] o_in16;

  task automatic run_frame(input logic [31:0] f, input int d,
                           input int hi, input int lo, input int nbits);
    o_rd14 = 0; o_wr32 = 0; o_err2 = 0;
    o_vld16 = 0; o_in16 = 0; o_busy32 = 0;
    for (int b = 1; b <= nbits; b++) begin
      MDIO_OUT = f[32-b];
      MDIO_OE  = (d == 0) || (b < d);
      MDC      = 1'b1;
      @(negedge clk);
      if (b == 16) begin
        o_vld16 = MDIO_IN_VLD;
        o_in16  = MDIO_IN;
      end
      if (b == 32) o_busy32 = BUSY;
      @(posedge clk); #1;
      if (b == 2)  o_err2 = FRAME_ERR;
      if (b == 14) o_rd14 = RD_REQ;
      if (b == 32) o_wr32 = WR_STB;
      repeat (hi - 1) begin @(posedge clk); #1; end
      MDC = 1'b0;
      repeat (lo) begin @(posedge clk); #1; end
    end
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    int w0, r0, e0, b0;
    logic [4:0]  ra;
    logic [15:0] want;
    w0 = wr_n; r0 = rd_n; e0 = err_n; b0 = both_n;
    ra = v.frame[22:18];
    run_frame(v.frame, v.drop, v.hi, v.lo, 32);
    chk({tag, ".rd_req"}, o_rd14, v.exp_rd);
    chk({tag, ".rd_cnt"}, rd_n - r0, v.exp_rd);
    if (v.exp_rd) begin
      want = mem[ra];
      chk({tag, ".rd_addr"}, rd_reg, ra);
      chk({tag, ".vld16"}, o_vld16, 1);
      chk({tag, ".in16"}, o_in16, want);
    end else if (v.drop != 1) begin
      chk({tag, ".vld16"}, o_vld16, 0);
    end
    chk({tag, ".wr_stb"}, o_wr32, v.exp_wr);
    chk({tag, ".wr_cnt"}, wr_n - w0, v.exp_wr);
    if (v.exp_wr) begin
      chk({tag, ".wr_addr"}, wr_reg, ra);
      chk({tag, ".wr_data"}, wr_data, v.frame[15:0]);
    end
    chk({tag, ".err_cnt"}, err_n - e0, v.exp_err);
    chk({tag, ".err_bit2"}, o_err2, v.exp_err2);
    chk({tag, ".busy32"}, o_busy32, v.exp_busy32);
    chk({tag, ".idle"}, BUSY, 0);
    chk({tag, ".overlap"}, both_n - b0, 0);
  endtask

  vec_t vt [13];
  vec_t rv;

  initial begin
    for (int i = 0; i < 32; i++)
      mem[i] = 16'hA000 ^ 16'(i * 273);
    mem[5] = 16'h1234;

    // frame, drop, hi, lo, wr, rd, err, err@bit2, busy@bit32
    vt[0]  = '{32'h508E_ABCD, 0,  1, 1, 1, 0, 0, 0, 1};
    vt[1]  = '{32'h4096_0000, 17, 1, 1, 0, 1, 0, 0, 1};
    vt[2]  = '{32'h510E_FFFF, 0,  1, 1, 0, 0, 0, 0, 1};
    vt[3]  = '{32'h1086_ABCD, 0,  1, 1, 0, 0, 1, 1, 1};
    vt[4]  = '{32'h508E_ABCD, 20, 1, 1, 0, 0, 1, 0, 0};
    vt[5]  = '{32'h509E_00A5, 0,  1, 1, 1, 0, 0, 0, 1};
    vt[6]  = '{32'h508E_ABCD, 8,  1, 1, 0, 0, 1, 0, 0};
    vt[7]  = '{32'h4196_0000, 17, 1, 1, 0, 0, 0, 0, 0};
    vt[8]  = '{32'h50FE_1234, 0,  3, 2, 1, 0, 0, 0, 1};
    vt[9]  = '{32'h6092_BEEF, 0,  1, 2, 1, 0, 0, 0, 1};
    vt[10] = '{32'h7092_0F0F, 0,  2, 1, 1, 0, 0, 0, 1};
    vt[11] = '{32'h4096_0000, 0,  2, 2, 0, 1, 0, 0, 1};
    vt[12] = '{32'h40FE_0000, 17, 1, 3, 0, 1, 0, 0, 1};

    rst = 1'b0; MDC = 1'b0; MDIO_OUT = 1'b0; MDIO_OE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {MDIO_IN, MDIO_IN_VLD, REG_ADDR, WR_DATA,
         WR_STB, RD_REQ, FRAME_ERR, BUSY}, 0);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    for (int i = 0; i < 13; i++)
      do_frame(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a read header.
    run_frame(32'h4096_0000, 17, 1, 1, 9);
    chk("pre_rst_busy", BUSY, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs",
        {MDIO_IN, MDIO_IN_VLD, REG_ADDR, WR_DATA,
         WR_STB, RD_REQ, FRAME_ERR, BUSY}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    do_frame(vt[1], "post_rst_read");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  st, op;
      logic [4:0]  phy, ra;
      logic [15:0] dat;
      int          d, k, hi, lo;
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      op  = 2'($urandom);
      phy = ($urandom_range(0, 2) == 0) ? 5'($urandom) : PHY;
      ra  = 5'($urandom);
      dat = 16'($urandom);
      k   = $urandom_range(0, 9);
      if (k < 4) d = 0;
      else if (k == 9) d = 1;
      else d = $urandom_range(2, 31);
      if (d == 16) d = 17;
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      rv = model({st, op, phy, ra, 2'b10, dat}, d, hi, lo);
      do_frame(rv, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
